// File: rtl/charge_session_counter_pkg.sv
// Shared constants for the charge session counter: state encoding, legal
// per-Tick rates and the default saturation level.
package charge_session_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHARGING = 2'd1,
    ST_DONE     = 2'd2,
    ST_BAD      = 2'd3
  } state_e;

  localparam logic [3:0] RATE_SLOW = 4'd1;
  localparam logic [3:0] RATE_FAST = 4'd5;

  localparam int MAX_LEVEL_DEFAULT = 100;

  function automatic logic rate_legal(input logic [3:0] rate);
    return (rate == RATE_SLOW) || (rate == RATE_FAST);
  endfunction

endpackage

// File: rtl/charge_session_counter.sv
// Charge session counter: a timed session that accumulates a latched per-Tick
// rate into a saturating level, ending on timeout, full charge or user Stop.
module charge_session_counter
  import charge_session_counter_pkg::*;
#(
  parameter int MAX_LEVEL = MAX_LEVEL_DEFAULT
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        CounterEnable,
  input  logic [3:0]  CounterInput,
  input  logic        Start,
  input  logic        Stop,
  input  logic [11:0] SessionTime,
  input  logic        Tick,
  output logic [11:0] PresentTime,
  output logic [7:0]  ChargeLevel,
  output logic [1:0]  State,
  output logic        Busy,
  output logic        Done,
  output logic        Reject
);

  localparam logic [8:0] LP_MAX9 = 9'(MAX_LEVEL);
  localparam logic [7:0] LP_MAX8 = 8'(MAX_LEVEL);

  state_e      r_state;
  logic [11:0] r_time;
  logic [7:0]  r_level;
  logic [3:0]  r_rate;
  logic        r_busy;
  logic        r_done;
  logic        r_reject;

  state_e      w_state_nxt;
  logic [11:0] w_time_nxt;
  logic [11:0] w_time_dec;
  logic [7:0]  w_level_nxt;
  logic [7:0]  w_level_sat;
  logic [8:0]  w_sum;
  logic [3:0]  w_rate_nxt;
  logic        w_reject_nxt;
  logic        w_accept;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_time_nxt   = r_time;
    w_level_nxt  = r_level;
    w_rate_nxt   = r_rate;
    w_reject_nxt = 1'b0;
    w_sum        = {1'b0, r_level} + {5'b0, r_rate};
    w_level_sat  = (w_sum >= LP_MAX9) ? LP_MAX8 : w_sum[7:0];
    w_time_dec   = r_time - 12'd1;
    w_accept     = (CounterEnable == 1'b1) && rate_legal(CounterInput) &&
                   (SessionTime != 12'd0);
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          if (w_accept) begin
            w_state_nxt = ST_CHARGING;
            w_time_nxt  = SessionTime;
            w_level_nxt = 8'd0;
            w_rate_nxt  = CounterInput;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      ST_CHARGING: begin
        // Stop wins over a coincident Tick: the session ends with no update.
        if (Stop) begin
          w_state_nxt = ST_DONE;
          w_time_nxt  = 12'd0;
        end else if (Tick) begin
          w_level_nxt = w_level_sat;
          if ((w_time_dec == 12'd0) || (w_level_sat == LP_MAX8)) begin
            w_state_nxt = ST_DONE;
            w_time_nxt  = 12'd0;
          end else begin
            w_time_nxt = w_time_dec;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_time_nxt  = 12'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_time   <= 12'd0;
      r_level  <= 8'd0;
      r_rate   <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_time   <= w_time_nxt;
      r_level  <= w_level_nxt;
      r_rate   <= w_rate_nxt;
      r_busy   <= (w_state_nxt == ST_CHARGING);
      r_done   <= (w_state_nxt == ST_DONE);
      r_reject <= w_reject_nxt;
    end
  end

  assign PresentTime = r_time;
  assign ChargeLevel = r_level;
  assign State       = r_state;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Reject      = r_reject;

endmodule

// File: tb/tb_charge_session_counter.sv
// Randomized and directed bench for charge_session_counter against a
// session-level reference model kept in plain integers.
module tb_charge_session_counter;

  localparam int MAXL = 100;

  logic        Clock;
  logic        ResetN;
  logic        CounterEnable;
  logic [3:0]  CounterInput;
  logic        Start;
  logic        Stop;
  logic [11:0] SessionTime;
  logic        Tick;
  logic [11:0] PresentTime;
  logic [7:0]  ChargeLevel;
  logic [1:0]  State;
  logic        Busy;
  logic        Done;
  logic        Reject;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // reference model: mode 0 idle, 1 charging, 2 done
  int m_mode, m_rem, m_lvl, m_rate, m_done, m_rej;

  charge_session_counter #(.MAX_LEVEL(MAXL)) dut (
    .Clock(Clock), .ResetN(ResetN), .CounterEnable(CounterEnable),
    .CounterInput(CounterInput), .Start(Start), .Stop(Stop),
    .SessionTime(SessionTime), .Tick(Tick), .PresentTime(PresentTime),
    .ChargeLevel(ChargeLevel), .State(State), .Busy(Busy), .Done(Done),
    .Reject(Reject)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_rem = 0; m_lvl = 0; m_rate = 0; m_done = 0; m_rej = 0;
  endtask

  // One session-rule step, evaluated with the inputs present at the edge.
  task automatic m_edge(input bit st, input bit sp, input bit tk);
    int ci;
    ci = int'(CounterInput);
    m_rej = 0;
    if (m_mode == 0) begin
      if (st) begin
        if (CounterEnable === 1'b1 && (ci == 1 || ci == 5) && SessionTime != 0) begin
          m_mode = 1; m_rem = int'(SessionTime); m_lvl = 0; m_rate = ci;
        end else m_rej = 1;
      end
    end else if (m_mode == 1) begin
      if (sp) begin
        m_mode = 2; m_rem = 0;
      end else if (tk) begin
        m_rem = m_rem - 1;
        m_lvl = (m_lvl + m_rate > MAXL) ? MAXL : m_lvl + m_rate;
        if (m_rem == 0 || m_lvl == MAXL) begin
          m_mode = 2; m_rem = 0;
        end
      end
    end else begin
      m_mode = 0;
    end
    m_done = (m_mode == 2) ? 1 : 0;
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, ".state"}, int'(State), m_mode);
    chk({pfx, ".ptime"}, int'(PresentTime), m_rem);
    chk({pfx, ".level"}, int'(ChargeLevel), m_lvl);
    chk({pfx, ".busy"}, int'(Busy), (m_mode == 1) ? 1 : 0);
    chk({pfx, ".done"}, int'(Done), m_done);
    chk({pfx, ".reject"}, int'(Reject), m_rej);
  endtask

  task automatic step(input string pfx, input bit st, input bit sp, input bit tk);
    Start = st; Stop = sp; Tick = tk;
    @(posedge Clock);
    m_edge(st, sp, tk);
    #1;
    if (Done === 1'b1) done_cnt++;
    compare_all(pfx);
    Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
  endtask

  task automatic setup(input bit en, input int ci, input int st);
    CounterEnable = en;
    CounterInput  = 4'(ci);
    SessionTime   = 12'(st);
  endtask

  initial begin
    int vals[8];
    ResetN = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
    setup(1'b0, 0, 0);
    m_reset();
    #2;
    compare_all("reset");
    #10 ResetN = 1'b1;

    // rate 1, three Ticks
    setup(1'b1, 1, 3);
    step("r36.start", 1, 0, 0);
    chk("r36.pt_load", int'(PresentTime), 3);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) step("r36.tick", 0, 0, 1);
    chk("r36.level", int'(ChargeLevel), 3);
    step("r36.idle", 0, 0, 0);
    chk("r36.state_back", int'(State), 0);
    chk("r36.done_pulses", done_cnt, 1);

    // rate 5, saturate on Tick 20
    setup(1'b1, 5, 30);
    step("r37.start", 1, 0, 0);
    for (int i = 0; i < 19; i++) step("r37.tick", 0, 0, 1);
    chk("r37.pt_before", int'(PresentTime), 11);
    step("r37.tick20", 0, 0, 1);
    chk("r37.level", int'(ChargeLevel), 100);
    chk("r37.state_done", int'(State), 2);
    step("r37.after", 0, 0, 1);
    chk("r37.pt_after", int'(PresentTime), 0);

    // refused starts
    setup(1'b0, 1, 5);  step("r38.en0", 1, 0, 0);
    chk("r38.rej_en", int'(Reject), 1);
    setup(1'b1, 4, 5);  step("r38.ci4", 1, 0, 0);
    chk("r38.rej_ci", int'(Reject), 1);
    setup(1'b1, 5, 0);  step("r38.st0", 1, 0, 0);
    chk("r38.rej_st", int'(Reject), 1);
    chk("r38.level_kept", int'(ChargeLevel), 100);
    step("r38.clear", 0, 0, 0);

    // Stop overrides Tick; rate change mid-session ignored; Start ignored
    setup(1'b1, 1, 10);
    step("r39.start", 1, 0, 0);
    step("r39.tick", 0, 0, 1);
    setup(1'b0, 5, 10);
    step("r41.tick", 0, 0, 1);
    chk("r41.still1", int'(ChargeLevel), 2);
    step("r21.start_busy", 1, 0, 1);
    step("r39.tick", 0, 0, 1);
    step("r39.stop", 0, 1, 1);
    chk("r39.level", int'(ChargeLevel), 4);
    chk("r39.state", int'(State), 2);
    step("r39.idle", 0, 0, 0);
    chk("r39.pt", int'(PresentTime), 0);

    // reset mid-session between edges
    setup(1'b1, 5, 8);
    step("r40.start", 1, 0, 0);
    step("r40.tick", 0, 0, 1);
    step("r40.tick", 0, 0, 1);
    #2 ResetN = 1'b0;
    m_reset();
    #1;
    compare_all("r40.async");
    #2 ResetN = 1'b1;
    done_cnt = 0;
    step("r40.post", 0, 0, 1);
    chk("r40.no_done", done_cnt, 0);
    step("r40.restart", 1, 0, 0);
    chk("r40.accepted", int'(State), 1);

    // randomized traffic
    vals = '{1, 5, 1, 5, 4, 0, 3, 15};
    for (int n = 0; n < 2000; n++) begin
      setup(($urandom_range(0, 9) != 0), vals[$urandom_range(0, 7)],
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30));
      step("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/charge_session_counter.md
CHARGE_SESSION_COUNTER -- requirements
Module: charge_session_counter

Interface
REQ-001 Parameter: MAX_LEVEL, 100, saturation and full-charge threshold for ChargeLevel (legal range 1..255).
REQ-002 Port: Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: ResetN  input  1  asynchronous, active-low reset.
REQ-004 Port: CounterEnable  input  1  rate-valid flag from the upstream controller; counts as valid only when exactly 1 (0/X/Z = invalid).
REQ-005 Port: CounterInput  input  4  charge units per Tick from the upstream controller; legal values 1 and 5.
REQ-006 Port: Start  input  1  single-cycle session start request.
REQ-007 Port: Stop  input  1  single-cycle user abort.
REQ-008 Port: SessionTime  input  12  session duration in Ticks, sampled on an accepted Start.
REQ-009 Port: Tick  input  1  single-cycle time-base strobe.
REQ-010 Port: PresentTime  output  12  remaining Ticks; fed back to the upstream controller.
REQ-011 Port: ChargeLevel  output  8  accumulated charge units.
REQ-012 Port: State  output  2  IDLE=0, CHARGING=1, DONE=2.
REQ-013 Port: Busy  output  1  high while State==CHARGING.
REQ-014 Port: Done  output  1  one-cycle pulse on session end.
REQ-015 Port: Reject  output  1  one-cycle pulse on a refused Start.

Function
REQ-016 The FSM SHALL have states IDLE, CHARGING and DONE; encoding 3 is unreachable and SHALL recover to IDLE on the next edge.
REQ-017 In IDLE, PresentTime SHALL be 0, which lets the upstream controller present a rate.
REQ-018 A Start in IDLE SHALL be accepted only when CounterEnable==1, CounterInput is 1 or 5, and SessionTime!=0.
REQ-019 Accepted Start, on the next edge: latch CounterInput into an internal rate register, load PresentTime=SessionTime, clear ChargeLevel to 0, enter CHARGING.
REQ-020 A refused Start in IDLE SHALL pulse Reject for one cycle; State stays IDLE and ChargeLevel is unchanged.
REQ-021 Start outside IDLE SHALL be ignored without a Reject pulse.
REQ-022 The latched rate SHALL govern the whole session; CounterInput and CounterEnable changes during CHARGING are ignored.
REQ-023 Each Tick in CHARGING SHALL decrement PresentTime by 1 and add the latched rate to ChargeLevel, saturating at MAX_LEVEL (9-bit intermediate sum).
REQ-024 CHARGING SHALL exit to DONE on the edge where PresentTime becomes 0 or ChargeLevel reaches MAX_LEVEL, whichever occurs first (both on the same Tick: single exit).
REQ-025 Stop in CHARGING SHALL force DONE on the next edge and SHALL override a simultaneous Tick: no decrement, no accumulation.
REQ-026 On entry to DONE, PresentTime SHALL be 0; ChargeLevel SHALL be held.
REQ-027 DONE SHALL last exactly one cycle, with Done high during it, then return to IDLE.
REQ-028 ChargeLevel SHALL hold its final value in IDLE until the next accepted Start.
REQ-029 Tick in IDLE or DONE SHALL have no effect.
REQ-030 Done, Reject and Busy SHALL be registered outputs.

Reset
REQ-031 ResetN low SHALL immediately force State=IDLE, PresentTime=0, ChargeLevel=0, rate register=0, and Busy=Done=Reject=0.
REQ-032 Reset mid-session SHALL abort the session without a Done pulse.
REQ-033 The first edge after ResetN deasserts SHALL evaluate inputs normally.

Structure
REQ-034 A shared package SHALL hold the state encoding constants (IDLE/CHARGING/DONE), the legal rate constants (1, 5) and the MAX_LEVEL default.
REQ-035 The block SHALL be a single module with no sub-modules; the FSM, down-counter and saturating accumulator are in-line.

Verification
REQ-036 Rate 1, SessionTime=3, Start, then 3 Ticks -> PresentTime 3,2,1,0; ChargeLevel 1,2,3; Done pulses once; State returns to 0.
REQ-037 Rate 5, SessionTime=30, Start, then 20 Ticks -> ChargeLevel reaches 100 on Tick 20 with PresentTime=10; then DONE, after which PresentTime=0.
REQ-038 CounterEnable=0, or CounterInput=4, or SessionTime=0, then Start -> Reject pulse; State=0; ChargeLevel unchanged.
REQ-039 Rate 1, SessionTime=10, 4 Ticks, then Stop and Tick in the same cycle -> ChargeLevel=4; DONE; PresentTime=0 afterward.
REQ-040 Rate 5, SessionTime=8, 2 Ticks, then ResetN low between edges -> outputs 0 immediately; no Done pulse; a subsequent Start is accepted.
REQ-041 Mid-session, change CounterInput 1->5 -> increments stay 1 per Tick.
